// File: rtl/audio_mix_sequencer.sv
// Sequences NUM_CH channel samples through one shared external prefilter.
// Enabled prefilter results are summed with unsigned saturation into one mixed sample per strobe.
module audio_mix_sequencer #(
  parameter int AUDIO_DW = 16,
  parameter int NUM_CH   = 4,
  parameter int CH_W     = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sample_stb,
  input  logic [NUM_CH*AUDIO_DW-1:0] ch_din,
  input  logic [NUM_CH-1:0]          ch_en,
  output logic [AUDIO_DW-1:0]        pf_din,
  input  logic [AUDIO_DW-1:0]        pf_dout,
  output logic [AUDIO_DW-1:0]        dout,
  output logic                       dout_valid,
  output logic                       busy,
  output logic                       overrun
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t              state, state_nxt;
  logic [CH_W-1:0]     idx;
  logic [AUDIO_DW-1:0] acc, acc_nxt;
  logic [AUDIO_DW-1:0] snap [NUM_CH];
  logic [NUM_CH-1:0]   snap_en;
  logic [AUDIO_DW:0]   sum;
  logic                last;

  assign last = (idx == CH_W'(NUM_CH - 1));
  assign busy = (state != IDLE);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    pf_din    = '0;
    acc_nxt   = acc;
    sum       = {1'b0, acc} + {1'b0, pf_dout};
    case (state)
      IDLE: if (sample_stb) state_nxt = ACCUM;
      ACCUM: begin
        pf_din = snap[idx];
        // The carry out of the widened sum flags overflow; a saturated acc stays saturated.
        if (snap_en[idx]) acc_nxt = sum[AUDIO_DW] ? {AUDIO_DW{1'b1}} : sum[AUDIO_DW-1:0];
        if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      acc        <= '0;
      snap_en    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
      // NOTE: the snapshot array is small register storage, not RAM, so it is cleared on reset.
      for (int k = 0; k < NUM_CH; k++) snap[k] <= '0;
    end else begin
      state      <= state_nxt;
      dout_valid <= (state == ACCUM) && last;
      overrun    <= sample_stb && (state != IDLE);
      case (state)
        IDLE: if (sample_stb) begin
          for (int k = 0; k < NUM_CH; k++) snap[k] <= ch_din[k*AUDIO_DW +: AUDIO_DW];
          snap_en <= ch_en;
          acc     <= '0;
          idx     <= '0;
        end
        ACCUM: begin
          acc <= acc_nxt;
          idx <= idx + 1'b1;
          if (last) dout <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/audio_mix_sequencer.md
Name: audio_mix_sequencer

Overview:
- Time-multiplexes one shared audio prefilter across NUM_CH source channels.
- The prefilter maps sign-set samples to all-ones and passes other samples unchanged.
- On each sample strobe the block snapshots all channels, drives them through the prefilter one per cycle, and accumulates the enabled results with unsigned saturation.
- Emits one mixed sample per strobe; sits between the channel sources and the audio output stage.

Parameters:
- AUDIO_DW, 16, sample width in bits (channel, prefilter and output).
- NUM_CH, 4, number of source channels (>= 2).
- CH_W, 2, channel index width; must satisfy 2**CH_W >= NUM_CH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sample_stb  in  1  one-cycle pulse requesting a mix pass.
- ch_din  in  NUM_CH*AUDIO_DW  channel samples; channel k occupies bits [k*AUDIO_DW +: AUDIO_DW].
- ch_en  in  NUM_CH  per-channel enable; bit k gates channel k.
- pf_din  out  AUDIO_DW  sample presented to the shared prefilter.
- pf_dout  in  AUDIO_DW  prefilter result; combinational from pf_din, same cycle.
- dout  out  AUDIO_DW  mixed sample; registered, held until the next pass completes.
- dout_valid  out  1  one-cycle pulse marking a new dout.
- busy  out  1  high while a pass is in progress (state != IDLE).
- overrun  out  1  one-cycle pulse when sample_stb arrives while busy.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; idx, acc, snapshots, dout and pf_din are 0.
  - dout_valid, busy and overrun are 0.
  - Takes effect immediately, mid-pass included; the aborted pass produces no dout_valid.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - pf_din=0.
  - sample_stb=1 → snapshot ch_din and ch_en into registers, acc<=0, idx<=0, go to ACCUM.
- ACCUM (NUM_CH cycles, idx=0..NUM_CH-1):
  - pf_din = snap[idx].
  - If snap_en[idx]=1: acc <= sat(acc + pf_dout). Otherwise acc is unchanged.
  - idx<=idx+1. When idx=NUM_CH-1: load dout<=final acc (including this cycle's term), set dout_valid<=1, go to DONE.
- DONE (1 cycle):
  - dout_valid=1, pf_din=0, go to IDLE.
  - dout_valid deasserts the following cycle.
- Saturation:
  - Sum is formed at AUDIO_DW+1 bits; if bit AUDIO_DW is set, result = {AUDIO_DW{1'b1}}.
  - Once saturated, acc stays all-ones for the rest of the pass.
- Timing (strobe sampled at edge of cycle 0):
  - ACCUM occupies cycles 1..NUM_CH.
  - dout_valid is high in cycle NUM_CH+1.
  - The earliest next accepted strobe is cycle NUM_CH+2.
  - Throughput: one pass per NUM_CH+2 cycles.
- Input stability: ch_din and ch_en changes after the snapshot do not affect the current pass.
- Strobe while busy (ACCUM or DONE):
  - Ignored; overrun=1 the following cycle for one cycle.
  - The current pass completes unaffected.
  - One overrun pulse per offending strobe cycle.
- All channels disabled → dout=0 with dout_valid pulsed as normal.
- dout holds its last value indefinitely between passes.
- busy is 1 from cycle 1 through cycle NUM_CH+1 inclusive.

Test Plan:
- Basic mix: NUM_CH=4, ch_din={0x0004,0x0030,0x0200,0x1000} (ch3..ch0), ch_en=4'b1111, strobe at cycle 0 → pf_din steps 0x1000,0x0200,0x0030,0x0004 in cycles 1-4; dout_valid=1 and dout=0x1234 in cycle 5; busy 0 in cycle 6.
- Saturation: ch0=0x8000 (prefilter→0xFFFF), ch1=0x0001, all enabled → dout=0xFFFF. Also ch0=0x7000, ch1=0x7000, ch2=0x2000, ch3=0 → dout=0xFFFF.
- Enable mask: same data as basic mix, ch_en=4'b0101 → dout=0x1030. ch_en=0 → dout=0x0000 with a dout_valid pulse.
- Snapshot/overrun: change ch_din to all 0x7FFF in cycle 2 and pulse sample_stb in cycle 3 → overrun high in cycle 4 only; dout=0x1234 in cycle 5; exactly one dout_valid. A strobe at cycle 6 is accepted with no overrun.
- Reset mid-pass: assert reset_n=0 during cycle 2 of a pass → busy, dout, dout_valid and pf_din go to 0 immediately; no dout_valid follows. After release, a fresh strobe yields the correct result NUM_CH+1 cycles later.
- Back-to-back: strobes at cycles 0 and 6 with different data → two dout_valid pulses at cycles 5 and 11 carrying the respective sums; no overrun.
